// File: rtl/acc_psum_buffer.sv
// rtl/acc_psum_buffer.sv - per-column partial-sum accumulator between systolic array and ofmap output
// Optional ACC_SAT_EN: saturating lane sums with sticky overflow_o; otherwise sums wrap and overflow_o is 0.
module acc_psum_buffer #(
  parameter int PE_SIZE        = 14,
  parameter int PSUM_WIDTH     = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int WEIGHT_ROW_NUM = 294,
  parameter int WEIGHT_COL_NUM = 70,
  localparam int ACC_CNT_NUM   = WEIGHT_ROW_NUM / PE_SIZE,
  localparam int CW            = (WEIGHT_COL_NUM > 1) ? $clog2(WEIGHT_COL_NUM) : 1,
  localparam int PW            = (ACC_CNT_NUM > 1) ? $clog2(ACC_CNT_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear_i,
  input  logic                            psum_en_i,
  input  logic [PE_SIZE*PSUM_WIDTH-1:0]   psum_i,
  output logic [PE_SIZE*ACC_WIDTH-1:0]    ofmap_o,
  output logic                            ofmap_valid_o,
  output logic [CW-1:0]                   ofmap_col_o,
  output logic [PW-1:0]                   pass_idx_o,
  output logic                            busy_o,
  output logic                            overflow_o
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [CW-1:0]                col_cnt_q, col_cnt_d;
  logic [PW-1:0]                pass_cnt_q, pass_cnt_d;
  logic [PE_SIZE*ACC_WIDTH-1:0] ofmap_q, ofmap_d;
  logic                         valid_q, valid_d;
  logic [CW-1:0]                ofcol_q, ofcol_d;

  logic [ACC_WIDTH-1:0] buf_q [WEIGHT_COL_NUM][PE_SIZE];
  logic [ACC_WIDTH-1:0] sum   [PE_SIZE];
  logic [ACC_WIDTH-1:0] base  [PE_SIZE];
  logic [ACC_WIDTH:0]   wide  [PE_SIZE];
  logic                 beat, last_col, last_pass;

  assign beat      = psum_en_i && !clear_i;
  assign last_col  = (col_cnt_q == CW'(WEIGHT_COL_NUM - 1));
  assign last_pass = (pass_cnt_q == PW'(ACC_CNT_NUM - 1));

  // Buffer is a flop array read combinationally, so a write on one edge is
  // already visible to the next beat even when WEIGHT_COL_NUM==1.
  always_comb begin
    for (int k = 0; k < PE_SIZE; k++) begin
      base[k] = (pass_cnt_q == '0) ? '0 : buf_q[col_cnt_q][k];
      wide[k] = {base[k][ACC_WIDTH-1], base[k]}
              + {{(ACC_WIDTH+1-PSUM_WIDTH){psum_i[k*PSUM_WIDTH+PSUM_WIDTH-1]}},
                 psum_i[k*PSUM_WIDTH +: PSUM_WIDTH]};
`ifdef ACC_SAT_EN
      if (wide[k][ACC_WIDTH] != wide[k][ACC_WIDTH-1])
        sum[k] = wide[k][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else
        sum[k] = wide[k][ACC_WIDTH-1:0];
`else
      sum[k] = wide[k][ACC_WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    col_cnt_d  = col_cnt_q;
    pass_cnt_d = pass_cnt_q;
    ofmap_d    = ofmap_q;
    valid_d    = 1'b0;
    ofcol_d    = ofcol_q;
    if (clear_i) begin
      col_cnt_d  = '0;
      pass_cnt_d = '0;
      ofmap_d    = '0;
      ofcol_d    = '0;
    end else if (psum_en_i) begin
      col_cnt_d = last_col ? '0 : col_cnt_q + 1'b1;
      if (last_col)
        pass_cnt_d = last_pass ? '0 : pass_cnt_q + 1'b1;
      if (last_pass) begin
        for (int k = 0; k < PE_SIZE; k++)
          ofmap_d[k*ACC_WIDTH +: ACC_WIDTH] = sum[k];
        valid_d = 1'b1;
        ofcol_d = col_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q  <= '0;
      pass_cnt_q <= '0;
      ofmap_q    <= '0;
      valid_q    <= 1'b0;
      ofcol_q    <= '0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      ofmap_q    <= ofmap_d;
      valid_q    <= valid_d;
      ofcol_q    <= ofcol_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat && !last_pass) begin
      for (int k = 0; k < PE_SIZE; k++)
        buf_q[col_cnt_q][k] <= sum[k];
    end
  end

`ifdef ACC_SAT_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (clear_i) begin
      overflow_d = 1'b0;
    end else if (psum_en_i) begin
      for (int k = 0; k < PE_SIZE; k++)
        if (wide[k][ACC_WIDTH] != wide[k][ACC_WIDTH-1])
          overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign ofmap_o       = ofmap_q;
  assign ofmap_valid_o = valid_q;
  assign ofmap_col_o   = ofcol_q;
  assign pass_idx_o    = pass_cnt_q;
  assign busy_o        = (col_cnt_q != '0) || (pass_cnt_q != '0);

endmodule

// File: tb/tb_acc_psum_buffer.sv
// tb/tb_acc_psum_buffer.sv - scoreboard bench for acc_psum_buffer (12-bit and 8-bit accumulator instances)
module tb_acc_psum_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clear_a = 1'b0, en_a = 1'b0;
  logic [15:0] psum_a  = '0;
  logic [23:0] ofmap_a;
  logic        valid_a, busy_a, ovf_a;
  logic [1:0]  col_a, pass_a;

  logic        clear_b = 1'b0, en_b = 1'b0;
  logic [15:0] psum_b  = '0;
  logic [15:0] ofmap_b;
  logic        valid_b, busy_b, ovf_b;
  logic [1:0]  col_b, pass_b;

  acc_psum_buffer #(.PE_SIZE(2), .PSUM_WIDTH(8), .ACC_WIDTH(12),
                    .WEIGHT_ROW_NUM(6), .WEIGHT_COL_NUM(4)) dut_a (
    .clk(clk), .rst(rst), .clear_i(clear_a), .psum_en_i(en_a), .psum_i(psum_a),
    .ofmap_o(ofmap_a), .ofmap_valid_o(valid_a), .ofmap_col_o(col_a),
    .pass_idx_o(pass_a), .busy_o(busy_a), .overflow_o(ovf_a));

  acc_psum_buffer #(.PE_SIZE(2), .PSUM_WIDTH(8), .ACC_WIDTH(8),
                    .WEIGHT_ROW_NUM(6), .WEIGHT_COL_NUM(4)) dut_b (
    .clk(clk), .rst(rst), .clear_i(clear_b), .psum_en_i(en_b), .psum_i(psum_b),
    .ofmap_o(ofmap_b), .ofmap_valid_o(valid_b), .ofmap_col_o(col_b),
    .pass_idx_o(pass_b), .busy_o(busy_b), .overflow_o(ovf_b));

  typedef struct { int l0; int l1; int col; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int l0, input int l1, input int col);
    exp_t e;
    e.l0 = l0; e.l1 = l1; e.col = col;
    return e;
  endfunction

  always @(negedge clk) begin
    logic signed [11:0] a0, a1;
    logic signed [7:0]  b0, b1;
    exp_t e;
    if (!rst && valid_a) begin
      a0 = ofmap_a[11:0];
      a1 = ofmap_a[23:12];
      if (q_a.size() == 0) begin
        chk("dut_a unexpected strobe", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("dut_a lane0", int'(a0), e.l0);
        chk("dut_a lane1", int'(a1), e.l1);
        chk("dut_a col", int'(col_a), e.col);
      end
    end
    if (!rst && valid_b) begin
      b0 = ofmap_b[7:0];
      b1 = ofmap_b[15:8];
      if (q_b.size() == 0) begin
        chk("dut_b unexpected strobe", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("dut_b lane0", int'(b0), e.l0);
        chk("dut_b lane1", int'(b1), e.l1);
        chk("dut_b col", int'(col_b), e.col);
      end
    end
  end

  task automatic beat_a(input int l0, input int l1);
    en_a = 1'b1;
    psum_a = {l1[7:0], l0[7:0]};
    @(posedge clk); #1;
  endtask

  task automatic beat_b(input int l0, input int l1);
    en_b = 1'b1;
    psum_b = {l1[7:0], l0[7:0]};
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset ofmap", int'(ofmap_a), 0);
    chk("reset valid", int'(valid_a), 0);
    chk("reset col", int'(col_a), 0);
    chk("reset pass", int'(pass_a), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset overflow", int'(ovf_a), 0);
    rst = 1'b0;
    idle(1);

    // 1: basic tile
    for (int c = 0; c < 4; c++) q_a.push_back(mk(15, 15, c));
    for (int i = 0; i < 12; i++) beat_a(5, 5);
    idle(1);
    chk("t1 busy after tile", int'(busy_a), 0);
    chk("t1 queue drained", q_a.size(), 0);

    // 2: signed values with gaps
    for (int c = 0; c < 4; c++) q_a.push_back(mk(-9, 3 * (c + 1), c));
    for (int i = 0; i < 12; i++) begin
      beat_a(-3, (i % 4) + 1);
      idle(1 + (i % 3));
      if (i == 5) begin
        chk("t2 busy in gap", int'(busy_a), 1);
        chk("t2 pass in gap", int'(pass_a), 1);
      end
    end
    chk("t2 queue drained", q_a.size(), 0);

    // 3: mid-tile abort, coincident beat dropped
    for (int i = 0; i < 6; i++) beat_a(7, 7);
    clear_a = 1'b1;
    beat_a(7, 7);
    clear_a = 1'b0;
    idle(1);
    chk("t3 ofmap cleared", int'(ofmap_a), 0);
    chk("t3 pass cleared", int'(pass_a), 0);
    chk("t3 busy cleared", int'(busy_a), 0);
    for (int c = 0; c < 4; c++) q_a.push_back(mk(3, 3, c));
    for (int i = 0; i < 12; i++) beat_a(1, 1);
    idle(2);
    chk("t3 queue drained", q_a.size(), 0);

    // 4: async reset at pass 1
    for (int i = 0; i < 5; i++) beat_a(9, 9);
    idle(0);
    chk("t4 pass before reset", int'(pass_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("t4 ofmap on reset", int'(ofmap_a), 0);
    chk("t4 pass on reset", int'(pass_a), 0);
    chk("t4 busy on reset", int'(busy_a), 0);
    #1 rst = 1'b0;
    idle(1);
    for (int c = 0; c < 4; c++) q_a.push_back(mk(6, -3, c));
    for (int i = 0; i < 12; i++) beat_a(2, -1);
    idle(2);
    chk("t4 queue drained", q_a.size(), 0);

    // 5: saturation on the 8-bit instance
    for (int c = 0; c < 4; c++) begin
`ifdef ACC_SAT_EN
      q_b.push_back(mk(127, 0, c));
`else
      q_b.push_back(mk(125, 0, c));
`endif
    end
    for (int i = 0; i < 12; i++) beat_b(127, 0);
    idle(2);
`ifdef ACC_SAT_EN
    chk("t5 overflow set", int'(ovf_b), 1);
    idle(3);
    chk("t5 overflow sticky", int'(ovf_b), 1);
`else
    chk("t5 overflow tied low", int'(ovf_b), 0);
`endif
    clear_b = 1'b1;
    idle(1);
    clear_b = 1'b0;
    chk("t5 overflow after clear", int'(ovf_b), 0);
    chk("t5 ofmap after clear", int'(ofmap_b), 0);
    chk("t5 queue drained", q_b.size(), 0);

    // 6: two tiles back to back
    for (int c = 0; c < 4; c++) q_a.push_back(mk(3 * c, 30, c));
    for (int c = 0; c < 4; c++) q_a.push_back(mk(3, -6, c));
    for (int i = 0; i < 12; i++) beat_a(i % 4, 10);
    for (int i = 0; i < 12; i++) beat_a(1, -2);
    idle(3);
    chk("t6 queue drained", q_a.size(), 0);
    chk("t6 busy after tiles", int'(busy_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
